// File: rtl/nios2_system_ocimem_pkg.sv
// Shared types and JTAG data-out bit positions for the OCI RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nios2_system_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_RD  = 2'd1,
        JTAG_RD = 2'd2
    } state_t;

    typedef enum logic {
        CPU  = 1'b0,
        JTAG = 1'b1
    } grant_t;

    // Bit positions inside the 38-bit jdo shift register
    localparam int JDO_W        = 38;
    localparam int JDO_RDQ      = 35;
    localparam int JDO_CLR      = 36;
    localparam int JDO_ADDR_LSB = 17;
    localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/nios2_system_ocimem_jtag_req.sv
// JTAG side of the OCI RAM arbiter: pulse decode, one-entry pending request, MonAReg, overrun flag.
// Latency: a pulse becomes a pending request visible the following cycle.
// Backpressure: none upstream; pulses arriving while a request is pending are dropped and flagged.
module nios2_system_ocimem_jtag_req
    import nios2_system_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              req_done,
    output logic              pend_vld,
    output logic              pend_is_write,
    output logic [31:0]       pend_data,
    output logic [ADDR_W-1:0] mon_a_reg,
    output logic              jtag_overrun,
    output logic              flag_clr
);

    logic any_pulse;
    logic queue_rd;
    logic queue_wr;
    logic accept;
    logic unused_jdo;

    assign any_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign queue_rd  = (take_action_ocimem_a & jdo[JDO_RDQ]) | take_no_action_ocimem_a;
    assign queue_wr  = take_action_ocimem_b;
    assign accept    = (queue_rd | queue_wr) & ~pend_vld;
    assign flag_clr  = take_action_ocimem_a & jdo[JDO_CLR];
    assign unused_jdo = ^{jdo[JDO_W-1], jdo[JDO_DATA_LSB-1:0]};

    // Pending entry: captured on an accepted pulse, released when the arbiter finishes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld      <= 1'b0;
            pend_is_write <= 1'b0;
            pend_data     <= '0;
        end else if (accept) begin
            pend_vld      <= 1'b1;
            pend_is_write <= queue_wr;
            pend_data     <= jdo[JDO_DATA_LSB +: 32];
        end else if (req_done) begin
            pend_vld      <= 1'b0;
        end
    end

    // MonAReg: a direct load always wins over the post-access increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_a_reg <= '0;
        end else if (take_action_ocimem_a) begin
            mon_a_reg <= jdo[JDO_ADDR_LSB +: ADDR_W];
        end else if (req_done) begin
            mon_a_reg <= mon_a_reg + 1'b1;
        end
    end

    // Sticky overrun: any pulse seen while busy; an explicit clear takes priority
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_overrun <= 1'b0;
        end else if (flag_clr) begin
            jtag_overrun <= 1'b0;
        end else if (any_pulse && pend_vld) begin
            jtag_overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/nios2_system_nios2_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM between the CPU debug slave and JTAG requests (OCIMEM_ROM_PROTECT_EN adds low-word write protection).
// Latency: writes complete in the grant cycle; reads complete 2 cycles after grant (CPU waitrequest low on cycle 2).
// Backpressure: CPU held off with cpu_waitrequest; JTAG holds one pending request and drops/flags extras.
module nios2_system_nios2_ocimem_arbiter
    import nios2_system_ocimem_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int unsigned ROM_WORDS = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              debugack,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              mon_busy,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
`ifdef OCIMEM_ROM_PROTECT_EN
    output logic              rom_write_err,
`endif
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    if (64'(ROM_WORDS) > (64'd1 << ADDR_W)) begin : g_rom_words_bad
        $error("ROM_WORDS exceeds the RAM depth");
    end

    state_t            state, state_nxt;
    grant_t            last_grant, grant_nxt;
    logic              run;
    logic [31:0]       readdata_q;
    logic [31:0]       mon_d_reg;
    logic              jtag_done;
    logic              wr_blocked;
    logic              cpu_req;
    logic              pick_jtag;
    logic              cpu_wr_prot;
    logic              jtag_wr_prot;
    logic              pend_vld;
    logic              pend_is_write;
    logic [31:0]       pend_data;
    logic [ADDR_W-1:0] mon_a_reg;
    logic              flag_clr;

    nios2_system_ocimem_jtag_req #(
        .ADDR_W (ADDR_W)
    ) u_jtag_req (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .req_done                (jtag_done),
        .pend_vld                (pend_vld),
        .pend_is_write           (pend_is_write),
        .pend_data               (pend_data),
        .mon_a_reg               (mon_a_reg),
        .jtag_overrun            (jtag_overrun),
        .flag_clr                (flag_clr)
    );

    assign MonDReg  = mon_d_reg;
    assign mon_busy = pend_vld;
    assign cpu_req  = cpu_read | cpu_write;
    // JTAG wins under debugack, when alone, or when it is its turn in the round robin
    assign pick_jtag = pend_vld & (debugack | ~cpu_req | (last_grant == CPU));

`ifdef OCIMEM_ROM_PROTECT_EN
    function automatic logic in_rom(input logic [ADDR_W-1:0] a);
        return 32'(a) < ROM_WORDS;
    endfunction
    assign cpu_wr_prot  = in_rom(cpu_address);
    assign jtag_wr_prot = in_rom(mon_a_reg);
`else
    assign cpu_wr_prot  = 1'b0;
    assign jtag_wr_prot = 1'b0;
`endif

    // Grant decision, RAM strobes and CPU handshake; run gates everything off while in reset
    always_comb begin
        state_nxt       = state;
        grant_nxt       = last_grant;
        ram_en          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = '0;
        ram_be          = '0;
        ram_wdata       = '0;
        cpu_waitrequest = 1'b1;
        cpu_readdata    = readdata_q;
        jtag_done       = 1'b0;
        wr_blocked      = 1'b0;
        case (state)
            IDLE: begin
                if (run && pick_jtag) begin
                    grant_nxt = JTAG;
                    ram_en    = 1'b1;
                    ram_addr  = mon_a_reg;
                    ram_be    = 4'hF;
                    if (pend_is_write) begin
                        wr_blocked = jtag_wr_prot;
                        ram_we     = ~jtag_wr_prot;
                        ram_wdata  = pend_data;
                        jtag_done  = 1'b1;
                    end else begin
                        state_nxt = JTAG_RD;
                    end
                end else if (run && cpu_req) begin
                    grant_nxt = CPU;
                    ram_en    = 1'b1;
                    ram_addr  = cpu_address;
                    ram_be    = cpu_byteenable;
                    if (cpu_write) begin
                        wr_blocked      = cpu_wr_prot;
                        ram_we          = ~cpu_wr_prot;
                        ram_wdata       = cpu_writedata;
                        cpu_waitrequest = 1'b0;
                    end else begin
                        state_nxt = CPU_RD;
                    end
                end
            end
            CPU_RD: begin
                cpu_waitrequest = 1'b0;
                cpu_readdata    = ram_rdata;
                state_nxt       = IDLE;
            end
            JTAG_RD: begin
                jtag_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, round-robin history and read-data holding registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= CPU;
            run        <= 1'b0;
            readdata_q <= '0;
            mon_d_reg  <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= grant_nxt;
            run        <= 1'b1;
            if (state == CPU_RD) begin
                readdata_q <= ram_rdata;
            end
            if (state == JTAG_RD) begin
                mon_d_reg <= ram_rdata;
            end
        end
    end

`ifdef OCIMEM_ROM_PROTECT_EN
    // Sticky blocked-write flag, cleared together with jtag_overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_write_err <= 1'b0;
        end else if (flag_clr) begin
            rom_write_err <= 1'b0;
        end else if (wr_blocked) begin
            rom_write_err <= 1'b1;
        end
    end
`else
    logic unused_prot;
    assign unused_prot = wr_blocked;
`endif

endmodule

// File: tb/tb_nios2_system_nios2_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a behavioural single-port RAM.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: fixed cycle scripts; a global time limit bounds the run.
module tb_nios2_system_nios2_ocimem_arbiter;

`ifdef OCIMEM_ROM_PROTECT_EN
    localparam bit ROM_ON = 1'b1;
`else
    localparam bit ROM_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        debugack;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [31:0] MonDReg;
    logic        mon_busy;
    logic        jtag_overrun;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
`ifdef OCIMEM_ROM_PROTECT_EN
    logic        rom_write_err;
`endif

    logic [31:0] mem [256];
    int          checks = 0;
    int          errors = 0;

    nios2_system_nios2_ocimem_arbiter #(
        .ADDR_W    (8),
        .ROM_WORDS (4)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .debugack                (debugack),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .MonDReg                 (MonDReg),
        .mon_busy                (mon_busy),
        .jtag_overrun            (jtag_overrun),
        .cpu_address             (cpu_address),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_writedata           (cpu_writedata),
        .cpu_byteenable          (cpu_byteenable),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
`ifdef OCIMEM_ROM_PROTECT_EN
        .rom_write_err           (rom_write_err),
`endif
        .ram_en                  (ram_en),
        .ram_we                  (ram_we),
        .ram_addr                (ram_addr),
        .ram_be                  (ram_be),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: preloaded while in reset, registered read data
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
            mem[3]    <= 32'hAAAA_AAAA;
            mem[8'h10] <= 32'hDEAD_BEEF;
            mem[8'h11] <= 32'hCAFE_F00D;
        end else if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [37:0] mk_a(input bit clr, input bit rd, input logic [7:0] a);
        logic [37:0] j;
        j        = '0;
        j[36]    = clr;
        j[35]    = rd;
        j[24:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] d);
        logic [37:0] j;
        j       = '0;
        j[34:3] = d;
        return j;
    endfunction

    typedef struct packed {
        logic       na;
        logic       rd;
        logic       dbg;
        logic       en;
        logic [7:0] addr;
        logic       wr;
    } arb_vec_t;

    arb_vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        // per cycle: pulse, cpu_read, debugack | ram_en, ram_addr, waitrequest
        tbl[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[1]  = {1'b0, 1'b1, 1'b0, 1'b1, 8'h12, 1'b1};
        tbl[2]  = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[3]  = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[4]  = {1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
        tbl[5]  = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[6]  = {1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 1'b1};
        tbl[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[8]  = {1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[9]  = {1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1};
        tbl[10] = {1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[11] = {1'b0, 1'b1, 1'b1, 1'b1, 8'h05, 1'b1};
        tbl[12] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[13] = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        reset_n = 1'b0; debugack = 1'b0; jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
        cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0; cpu_byteenable = 4'hF;

        // Reset state
        nxt(); nxt(); smp();
        check("rst_wait", 32'(cpu_waitrequest), 1);
        check("rst_en", 32'(ram_en), 0);
        check("rst_mond", MonDReg, 0);
        check("rst_busy", 32'(mon_busy), 0);
        check("rst_ovr", 32'(jtag_overrun), 0);
        check("rst_rdata", cpu_readdata, 0);
        nxt(); reset_n = 1'b1;
        nxt(); nxt();

        // JTAG read at 0x10 via take_action_ocimem_a
        nxt(); take_action_ocimem_a = 1'b1; jdo = mk_a(1'b0, 1'b1, 8'h10); smp();
        check("a_busy_pulse", 32'(mon_busy), 0);
        nxt(); take_action_ocimem_a = 1'b0; jdo = '0; smp();
        check("a_en", 32'(ram_en), 1);
        check("a_we", 32'(ram_we), 0);
        check("a_addr", 32'(ram_addr), 32'h10);
        check("a_busy", 32'(mon_busy), 1);
        nxt(); smp();
        check("a_rd_en", 32'(ram_en), 0);
        check("a_rd_busy", 32'(mon_busy), 1);
        nxt(); smp();
        check("a_mond", MonDReg, 32'hDEAD_BEEF);
        check("a_busy_fall", 32'(mon_busy), 0);
        nxt(); take_no_action_ocimem_a = 1'b1; smp();
        nxt(); take_no_action_ocimem_a = 1'b0; smp();
        check("a_inc_addr", 32'(ram_addr), 32'h11);
        nxt(); nxt(); smp();
        check("a_inc_mond", MonDReg, 32'hCAFE_F00D);

        // CPU write then read of address 3
        nxt(); cpu_write = 1'b1; cpu_address = 8'd3; cpu_writedata = 32'h1234_5678; cpu_byteenable = 4'b0011; smp();
        check("cw_en", 32'(ram_en), 1);
        check("cw_we", 32'(ram_we), ROM_ON ? 0 : 1);
        check("cw_be", 32'(ram_be), 32'h3);
        check("cw_addr", 32'(ram_addr), 3);
        check("cw_wdata", ram_wdata, 32'h1234_5678);
        check("cw_wait", 32'(cpu_waitrequest), 0);
        nxt(); cpu_write = 1'b0; cpu_read = 1'b1; cpu_byteenable = 4'hF; smp();
        check("cr_wait1", 32'(cpu_waitrequest), 1);
        check("cr_en", 32'(ram_en), 1);
        nxt(); smp();
        check("cr_wait2", 32'(cpu_waitrequest), 0);
        check("cr_data", cpu_readdata, ROM_ON ? 32'hAAAA_AAAA : 32'hAAAA_5678);
        nxt(); cpu_read = 1'b0; smp();
        check("cr_wait3", 32'(cpu_waitrequest), 1);

        // Arbitration script: round robin, then debugack priority
        cpu_address = 8'd5;
        for (int i = 0; i < 14; i++) begin
            nxt();
            take_no_action_ocimem_a = tbl[i].na;
            cpu_read                = tbl[i].rd;
            debugack                = tbl[i].dbg;
            smp();
            check($sformatf("arb%0d_en", i), 32'(ram_en), 32'(tbl[i].en));
            if (tbl[i].en) check($sformatf("arb%0d_addr", i), 32'(ram_addr), 32'(tbl[i].addr));
            check($sformatf("arb%0d_wait", i), 32'(cpu_waitrequest), 32'(tbl[i].wr));
            if (!tbl[i].wr) check($sformatf("arb%0d_rdata", i), cpu_readdata, 32'h1000_0005);
        end
        nxt(); take_no_action_ocimem_a = 1'b0; cpu_read = 1'b0; debugack = 1'b0; smp();
        check("arb_mond", MonDReg, 32'h1000_0014);

        // Overrun: second pulse one cycle later is dropped
        nxt(); take_no_action_ocimem_a = 1'b1; smp();
        check("ovr_before", 32'(jtag_overrun), 0);
        nxt(); smp();
        check("ovr_en", 32'(ram_en), 1);
        check("ovr_addr", 32'(ram_addr), 32'h15);
        nxt(); take_no_action_ocimem_a = 1'b0; smp();
        check("ovr_set", 32'(jtag_overrun), 1);
        nxt(); smp();
        check("ovr_no_second", 32'(ram_en), 0);
        check("ovr_idle_busy", 32'(mon_busy), 0);
        nxt(); take_action_ocimem_a = 1'b1; jdo = mk_a(1'b1, 1'b0, 8'hFF); smp();
        nxt(); take_action_ocimem_a = 1'b0; jdo = '0; smp();
        check("ovr_clr", 32'(jtag_overrun), 0);
        check("ovr_clr_busy", 32'(mon_busy), 0);

        // JTAG write at 0xFF, MonAReg wraps to 0x00
        nxt(); take_action_ocimem_b = 1'b1; jdo = mk_b(32'h0BAD_F00D); smp();
        nxt(); take_action_ocimem_b = 1'b0; jdo = '0; smp();
        check("wr_en", 32'(ram_en), 1);
        check("wr_we", 32'(ram_we), 1);
        check("wr_addr", 32'(ram_addr), 32'hFF);
        check("wr_be", 32'(ram_be), 32'hF);
        check("wr_wdata", ram_wdata, 32'h0BAD_F00D);
        nxt(); take_no_action_ocimem_a = 1'b1; smp();
        check("wr_busy_fall", 32'(mon_busy), 0);
        check("wr_mem", mem[255], 32'h0BAD_F00D);
        nxt(); take_no_action_ocimem_a = 1'b0; smp();
        check("wr_wrap_addr", 32'(ram_addr), 0);
        nxt(); nxt();

        // Reset asserted while in CPU_RD
        nxt(); cpu_read = 1'b1; cpu_address = 8'd5; smp();
        check("rr_en", 32'(ram_en), 1);
        nxt(); smp();
        check("rr_cpurd_wait", 32'(cpu_waitrequest), 0);
        #1 reset_n = 1'b0;
        #1;
        check("rr_wait", 32'(cpu_waitrequest), 1);
        check("rr_rdata", cpu_readdata, 0);
        check("rr_en_off", 32'(ram_en), 0);
        check("rr_mond", MonDReg, 0);
        cpu_read = 1'b0;
        nxt(); nxt(); reset_n = 1'b1;
        nxt(); nxt(); take_no_action_ocimem_a = 1'b1; smp();
        nxt(); take_no_action_ocimem_a = 1'b0; smp();
        check("rr_mona_zero", 32'(ram_addr), 0);
        nxt(); nxt();

`ifdef OCIMEM_ROM_PROTECT_EN
        // Protected low words: handshake completes, no write strobe
        nxt(); cpu_write = 1'b1; cpu_address = 8'd2; cpu_writedata = 32'h1111_1111; smp();
        check("rom_we", 32'(ram_we), 0);
        check("rom_wait", 32'(cpu_waitrequest), 0);
        nxt(); cpu_write = 1'b0; smp();
        check("rom_err", 32'(rom_write_err), 1);
        nxt(); take_action_ocimem_a = 1'b1; jdo = mk_a(1'b1, 1'b0, 8'h00); smp();
        nxt(); take_action_ocimem_a = 1'b0; jdo = '0; smp();
        check("rom_err_clr", 32'(rom_write_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios2_system_nios2_ocimem_arbiter.md
Name: nios2_system_nios2_ocimem_arbiter

Overview:
Arbitrates the single-port on-chip debug memory (OCI RAM) between two requesters: the CPU debug-slave port (Avalon-MM, waitrequest) and the JTAG debug module's sysclk-domain take_action pulses.
Owns MonAReg, an auto-incrementing address register, and MonDReg, which holds JTAG read data.
Sits between the sysclk half of the JTAG debug module and the OCI RAM instance, all in the clk domain.

Parameters:
ADDR_W, 8, OCI RAM word-address width
ROM_WORDS, 0, number of low words write-protected (used only with the optional feature)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
debugack  in  1  CPU halted in debug mode; JTAG gets absolute priority
jdo  in  38  JTAG data-out shift register
take_action_ocimem_a  in  1  1-cycle pulse: load MonAReg from jdo[ADDR_W+16:17]; if jdo[35]=1, also queue a read
take_action_ocimem_b  in  1  1-cycle pulse: queue a write of jdo[34:3] at MonAReg
take_no_action_ocimem_a  in  1  1-cycle pulse: queue a read at MonAReg
MonDReg  out  32  last JTAG read data
mon_busy  out  1  JTAG request pending or in flight
jtag_overrun  out  1  sticky: a JTAG pulse arrived while mon_busy=1
cpu_address  in  ADDR_W  CPU word address
cpu_read  in  1  CPU read request
cpu_write  in  1  CPU write request
cpu_writedata  in  32  CPU write data
cpu_byteenable  in  4  CPU byte enables
cpu_readdata  out  32  CPU read data
cpu_waitrequest  out  1  Avalon waitrequest
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_be  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid 1 cycle after ram_en with ram_we=0

Behaviour:
- Reset values:
  - MonAReg=0, MonDReg=0, mon_busy=0, jtag_overrun=0.
  - cpu_readdata=0, cpu_waitrequest=1, all ram_* outputs=0.
  - FSM=IDLE, last_grant=CPU.
- JTAG pending register:
  - Holds one entry {is_write, data}, captured on the pulse cycle.
  - Any pulse while mon_busy=1 is dropped and sets jtag_overrun.
  - take_action_ocimem_a with jdo[36]=1 clears jtag_overrun. It loads MonAReg even when busy.
- FSM states: IDLE, CPU_RD, JTAG_RD.
- IDLE arbitration:
  - Requesters are the CPU (cpu_read|cpu_write) and JTAG (pending entry valid).
  - debugack=1: JTAG wins.
  - Otherwise both requesting: grant the side other than last_grant. Only one requesting: grant it.
- CPU write grant: ram_en=ram_we=1 with CPU address/data/byteenable. cpu_waitrequest=0 in the same cycle. Stay in IDLE.
- CPU read grant: ram_en=1, go to CPU_RD.
  - CPU_RD: cpu_readdata<=ram_rdata and cpu_waitrequest=0 that cycle, then back to IDLE.
  - CPU read latency is 2 cycles minimum.
- JTAG write grant: ram_en=ram_we=1, ram_be=4'hF. Then MonAReg+1 (wraps mod 2^ADDR_W), clear pending, stay in IDLE.
- JTAG read grant: ram_en=1, go to JTAG_RD.
  - JTAG_RD: MonDReg<=ram_rdata, MonAReg+1, clear pending, back to IDLE.
- cpu_waitrequest is 1 in every cycle except the CPU completion cycles above.
- last_grant updates on each grant.
- mon_busy=1 from the cycle after the pulse until the cycle after completion.
- A pulse arriving in the completion cycle of the previous JTAG request is dropped, and overrun is set.
- ram_en is at most one per cycle. There is never a back-to-back grant out of CPU_RD or JTAG_RD; those states always return to IDLE first.
- Asynchronous reset mid-access: the access is abandoned and pending is lost. cpu_waitrequest returns to 1.

Optional Feature:
- Macro: OCIMEM_ROM_PROTECT_EN.
- Defined: writes from either side with address < ROM_WORDS do not assert ram_we.
  - The handshake still completes: CPU waitrequest goes low, and the JTAG MonAReg still increments.
  - Sticky output rom_write_err (1 bit, reset 0) sets on any blocked write. It clears with jtag_overrun.
- Undefined: no protection, and port rom_write_err is absent.

Decomposition:
- Package nios2_system_ocimem_pkg:
  - state enum (IDLE, CPU_RD, JTAG_RD)
  - grant enum (CPU, JTAG)
  - jdo bit-position constants (JDO_RDQ=35, JDO_CLR=36, JDO_ADDR_LSB=17, JDO_DATA_LSB=3)
- Sub-module nios2_system_ocimem_jtag_req: pulse decode, pending register, MonAReg, overrun flag.

Test Plan:
- take_action_ocimem_a with address 0x10 and jdo[35]=1, RAM[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF two cycles later; MonAReg=0x11; mon_busy falls.
- CPU write 0x12345678 to addr 3 with be=4'b0011 -> ram_we pulse with be=0011, waitrequest low the same cycle. CPU read of addr 3 -> waitrequest low on cycle 2 with readdata from RAM.
- CPU read held continuously, JTAG read queued, debugack=0 -> grants alternate CPU/JTAG. With debugack=1 -> JTAG granted first.
- Two take_no_action_ocimem_a pulses 1 cycle apart -> second dropped, jtag_overrun=1. take_action_ocimem_a with jdo[36]=1 -> flag cleared.
- MonAReg=0xFF with ADDR_W=8, JTAG write -> write lands at 0xFF, MonAReg wraps to 0x00.
- reset_n asserted in CPU_RD -> all outputs return to reset values immediately. With OCIMEM_ROM_PROTECT_EN and ROM_WORDS=4, a CPU write to addr 2 -> no ram_we, rom_write_err=1.
